ycr_wb_mem_tgt: RTL and testbench

YCR_WB_MEM_TGT -- requirements
Module: ycr_wb_mem_tgt

---
 rtl/ycr_wb_pkg.sv | 14 +
 rtl/ycr_wb_tgt_sram.sv | 29 ++
 rtl/ycr_wb_mem_tgt.sv | 193 +++++++++++++++++++
 tb/tb_ycr_wb_mem_tgt.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ycr_wb_pkg.sv
// Shared types and constants for the Wishbone burst memory target.
package ycr_wb_pkg;

  localparam int WB_BL_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_BEAT = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_TURN    = 3'd4
  } wb_tgt_state_e;

endpackage

// File: rtl/ycr_wb_tgt_sram.sv
// Single-port 2^AW x 32 SRAM with per-byte write enables and registered read.
module ycr_wb_tgt_sram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          cs,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  // rdata only changes on a read, so it holds its value across stalls
  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ycr_wb_mem_tgt.sv
// Wishbone burst target in front of a local SRAM window.
// Optional address range / wrap error checking: define YCR_WB_TGT_ERR_EN.
module ycr_wb_mem_tgt
  import ycr_wb_pkg::*;
#(
  parameter int          MEM_AW    = 8,
  parameter int          BL_W      = WB_BL_W,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic            wbd_stb_i,
  input  logic [31:0]     wbd_adr_i,
  input  logic            wbd_we_i,
  input  logic [31:0]     wbd_dat_i,
  input  logic [3:0]      wbd_sel_i,
  input  logic [BL_W-1:0] wbd_bl_i,
  input  logic            wbd_bry_i,
  output logic [31:0]     wbd_dat_o,
  output logic            wbd_ack_o,
  output logic            wbd_lack_o,
  output logic            wbd_err_o,
  output wb_tgt_state_e   dbg_state
);

  // Handshake: stb is held until lack. Each cycle with bry=1 in WR_BEAT or
  // RD_DATA is one accepted beat, answered by a registered ack the next
  // cycle; read data is shown in RD_DATA and kept on dat_o during its ack.
  wb_tgt_state_e     state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d, addr_inc;
  logic [BL_W-1:0]   cnt_q, cnt_d;
  logic [3:0]        sel_q, sel_d;
  logic              ack_q, ack_d, lack_q, lack_d;
  logic [31:0]       hold_q, hold_d;
  logic              mem_cs, mem_we;
  logic [31:0]       mem_rdata;
  logic              last_beat, addr_top, range_bad, wrap_blk;
  logic              unused_adr;

  assign addr_inc  = addr_q + MEM_AW'(1);
  assign addr_top  = &addr_q;
  assign last_beat = (cnt_q == BL_W'(1));

`ifdef YCR_WB_TGT_ERR_EN
  logic err_q, err_d, wrap_q, wrap_d;
  assign range_bad  = (wbd_adr_i[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2]);
  assign wrap_blk   = wrap_q;
  assign wbd_err_o  = err_q;
  assign unused_adr = ^wbd_adr_i[1:0];
`else
  assign range_bad  = 1'b0;
  assign wrap_blk   = 1'b0;
  assign wbd_err_o  = 1'b0;
  assign unused_adr = ^{wbd_adr_i[31:MEM_AW+2], wbd_adr_i[1:0], BASE_ADDR};
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    ack_d   = 1'b0;
    lack_d  = 1'b0;
    hold_d  = '0;
    mem_cs  = 1'b0;
    mem_we  = 1'b0;
`ifdef YCR_WB_TGT_ERR_EN
    err_d   = 1'b0;
    wrap_d  = wrap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (wbd_stb_i) begin
          addr_d  = wbd_adr_i[MEM_AW+1:2];
          sel_d   = wbd_sel_i;
          cnt_d   = (wbd_bl_i == '0) ? BL_W'(1) : wbd_bl_i;
          state_d = wbd_we_i ? ST_WR_BEAT : ST_RD_ADDR;
`ifdef YCR_WB_TGT_ERR_EN
          wrap_d  = 1'b0;
`endif
          if (range_bad) begin
            ack_d   = 1'b1;
            lack_d  = 1'b1;
            state_d = ST_TURN;
`ifdef YCR_WB_TGT_ERR_EN
            err_d   = 1'b1;
`endif
          end
        end
      end
      ST_WR_BEAT: begin
        if (wbd_bry_i) begin
          ack_d = 1'b1;
          if (wrap_blk) begin
            lack_d  = 1'b1;
            state_d = ST_TURN;
`ifdef YCR_WB_TGT_ERR_EN
            err_d   = 1'b1;
`endif
          end else begin
            mem_cs = 1'b1;
            mem_we = 1'b1;
            addr_d = addr_inc;
            cnt_d  = cnt_q - BL_W'(1);
`ifdef YCR_WB_TGT_ERR_EN
            wrap_d = addr_top;
`endif
            if (last_beat) begin
              lack_d  = 1'b1;
              state_d = ST_TURN;
            end
          end
        end
      end
      ST_RD_ADDR: begin
        if (wrap_blk) begin
          ack_d   = 1'b1;
          lack_d  = 1'b1;
          state_d = ST_TURN;
`ifdef YCR_WB_TGT_ERR_EN
          err_d   = 1'b1;
`endif
        end else begin
          mem_cs  = 1'b1;
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (wbd_bry_i) begin
          ack_d   = 1'b1;
          hold_d  = mem_rdata;
          addr_d  = addr_inc;
          cnt_d   = cnt_q - BL_W'(1);
          state_d = last_beat ? ST_TURN : ST_RD_ADDR;
          lack_d  = last_beat;
`ifdef YCR_WB_TGT_ERR_EN
          wrap_d  = addr_top;
`endif
        end
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      lack_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      lack_q  <= lack_d;
      hold_q  <= hold_d;
    end
  end

`ifdef YCR_WB_TGT_ERR_EN
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      wrap_q <= wrap_d;
    end
  end
`endif

  assign wbd_ack_o  = ack_q;
  assign wbd_lack_o = lack_q;
  assign wbd_dat_o  = (state_q == ST_RD_DATA) ? mem_rdata : hold_q;
  assign dbg_state  = state_q;

  ycr_wb_tgt_sram #(.AW(MEM_AW)) u_sram (
    .clk   (wb_clk),
    .cs    (mem_cs),
    .we    (mem_we),
    .be    (sel_q),
    .addr  (addr_q),
    .wdata (wbd_dat_i),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ycr_wb_mem_tgt.sv
// Self-checking bench for ycr_wb_mem_tgt: table vectors, hand corner cases, random bursts.
module tb_ycr_wb_mem_tgt;
  import ycr_wb_pkg::*;

  localparam int MEM_AW = 8;
  localparam int BL_W   = 10;
  localparam int WORDS  = 1 << MEM_AW;

  logic            wb_clk = 1'b0;
  logic            wb_rst;
  logic            wbd_stb_i, wbd_we_i, wbd_bry_i;
  logic [31:0]     wbd_adr_i, wbd_dat_i;
  logic [3:0]      wbd_sel_i;
  logic [BL_W-1:0] wbd_bl_i;
  logic [31:0]     wbd_dat_o;
  logic            wbd_ack_o, wbd_lack_o, wbd_err_o;
  wb_tgt_state_e   dbg_state;

  ycr_wb_mem_tgt #(.MEM_AW(MEM_AW), .BL_W(BL_W), .BASE_ADDR(32'h0)) dut (
    .wb_clk     (wb_clk),
    .wb_rst     (wb_rst),
    .wbd_stb_i  (wbd_stb_i),
    .wbd_adr_i  (wbd_adr_i),
    .wbd_we_i   (wbd_we_i),
    .wbd_dat_i  (wbd_dat_i),
    .wbd_sel_i  (wbd_sel_i),
    .wbd_bl_i   (wbd_bl_i),
    .wbd_bry_i  (wbd_bry_i),
    .wbd_dat_o  (wbd_dat_o),
    .wbd_ack_o  (wbd_ack_o),
    .wbd_lack_o (wbd_lack_o),
    .wbd_err_o  (wbd_err_o),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 wb_clk = ~wb_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [31:0] ref_mem [WORDS];
  logic [31:0] wbuf [WORDS];
  int          bry_pat [16];
  int          pat_len;
  logic [31:0] dlog [64];
  logic        alog [64];
  logic        llog [64];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [3:0]  sel;
    int          bl;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int word_idx(input logic [31:0] adr);
    return int'(adr[MEM_AW+1:2]);
  endfunction

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  // ---------------- driver: one complete burst, checked against the model ----------------
  // Cycle 0 is the IDLE cycle that samples stb; from cycle 1 every bry=1 cycle
  // of a write consumes one beat and must be acked in the following cycle.
  task automatic run_burst(input bit we, input logic [31:0] adr, input int bl,
                           input logic [3:0] sel, input int stall_pct);
    int n, idx, consumed, acks, cyc;
    bit done, b, pend;
    n = (bl == 0) ? 1 : bl;
    idx = word_idx(adr);
    exp_q.delete();
    if (!we) for (int k = 0; k < n; k++) exp_q.push_back(ref_mem[(idx + k) % WORDS]);
    wbd_stb_i = 1'b1;
    wbd_adr_i = adr;
    wbd_we_i  = we;
    wbd_sel_i = sel;
    wbd_bl_i  = BL_W'(bl);
    consumed = 0; acks = 0; cyc = 0; done = 0;
    while (!done && cyc < 3000) begin
      if (stall_pct < 0) b = (cyc >= 1 && cyc <= pat_len) ? (bry_pat[cyc-1] != 0) : 1'b1;
      else b = (int'($urandom_range(99)) >= stall_pct);
      wbd_bry_i = b;
      wbd_dat_i = (we && consumed < n) ? wbuf[consumed] : $urandom;
      pend = 1'b0;
      if (we && cyc >= 1 && b && consumed < n) begin
        ref_mem[(idx + consumed) % WORDS] = merge(ref_mem[(idx + consumed) % WORDS],
                                                  wbuf[consumed], sel);
        consumed++;
        pend = 1'b1;
      end
      tick();
      cyc++;
      if (cyc < 64) begin
        dlog[cyc] = wbd_dat_o;
        alog[cyc] = wbd_ack_o;
        llog[cyc] = wbd_lack_o;
      end
      if (we) begin
        check("wr_ack_timing", 32'(wbd_ack_o), 32'(pend));
        check("wr_dat_zero", wbd_dat_o, 32'h0);
      end
      if (wbd_ack_o) begin
        acks++;
        check("lack_on_last", 32'(wbd_lack_o), 32'(acks == n));
        check("err_low", 32'(wbd_err_o), 32'h0);
        if (!we) begin
          if (exp_q.size() == 0) check("rd_extra_ack", 32'(acks), 32'(n));
          else check("rd_data", wbd_dat_o, exp_q.pop_front());
          last_rd = wbd_dat_o;
        end
        if (wbd_lack_o) begin
          done = 1'b1;
          check("turn_state", 32'(dbg_state), 32'(ST_TURN));
        end
      end else begin
        check("lack_without_ack", 32'(wbd_lack_o), 32'h0);
      end
    end
    check("burst_done", 32'(done), 32'h1);
    check("ack_count", 32'(acks), 32'(n));
    wbd_stb_i = 1'b0;
    wbd_bry_i = 1'b0;
    tick();
    check("idle_after_turn", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- test sequence ----------------
  int          late_acks, n_r, idx_r, bl_r;
  logic [10:0] av, lv;
  logic [31:0] adr_r, old_w;
  bit          we_r;

  initial begin
    vecs[0]  = '{1'b1, 32'h10,  4'hF,    1, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,  4'hF,    1, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h14,  4'hF,    1, 32'h11223344, 32'h0};
    vecs[3]  = '{1'b1, 32'h14,  4'b0100, 1, 32'h00AB0000, 32'h0};
    vecs[4]  = '{1'b0, 32'h14,  4'hF,    1, 32'h0,        32'h11AB3344};
    vecs[5]  = '{1'b1, 32'h18,  4'hF,    0, 32'hA5A5A5A5, 32'h0};
    vecs[6]  = '{1'b0, 32'h18,  4'hF,    0, 32'h0,        32'hA5A5A5A5};
    vecs[7]  = '{1'b1, 32'h3FC, 4'hF,    1, 32'h0F0F0F0F, 32'h0};
    vecs[8]  = '{1'b0, 32'h3FC, 4'hF,    1, 32'h0,        32'h0F0F0F0F};
    vecs[9]  = '{1'b0, 32'h10,  4'hF,    0, 32'h0,        32'hDEADBEEF};
    vecs[10] = '{1'b1, 32'h10,  4'b1001, 1, 32'hFF0000EE, 32'h0};
    vecs[11] = '{1'b0, 32'h10,  4'hF,    1, 32'h0,        32'hFFADBEEE};

    // reset: inputs active but ignored
    wb_rst = 1'b1;
    wbd_stb_i = 1'b1; wbd_we_i = 1'b1; wbd_adr_i = 32'h40; wbd_dat_i = 32'h1234;
    wbd_sel_i = 4'hF; wbd_bl_i = BL_W'(2); wbd_bry_i = 1'b1;
    tick(); tick(); tick();
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_ack", 32'(wbd_ack_o), 32'h0);
    check("rst_lack", 32'(wbd_lack_o), 32'h0);
    check("rst_err", 32'(wbd_err_o), 32'h0);
    check("rst_dat", wbd_dat_o, 32'h0);

    // first request in the very first cycle out of reset: prefill all words
    wb_rst = 1'b0;
    for (int i = 0; i < WORDS; i++) wbuf[i] = $urandom;
    run_burst(1'b1, 32'h0, WORDS, 4'hF, 0);

    // table-driven single-beat vectors
    for (int i = 0; i < 12; i++) begin
      wbuf[0] = vecs[i].wdat;
      run_burst(vecs[i].we, vecs[i].adr, vecs[i].bl, vecs[i].sel, 0);
      if (!vecs[i].we) check($sformatf("table_rd[%0d]", i), last_rd, vecs[i].exp);
    end

    // write burst of 4 with bry 1,0,1,1,1, then read it back
    pat_len = 5;
    bry_pat[0] = 1; bry_pat[1] = 0; bry_pat[2] = 1; bry_pat[3] = 1; bry_pat[4] = 1;
    wbuf[0] = 32'hC0DE0001; wbuf[1] = 32'hC0DE0002; wbuf[2] = 32'hC0DE0003; wbuf[3] = 32'hC0DE0004;
    run_burst(1'b1, 32'h20, 4, 4'hF, -1);
    run_burst(1'b0, 32'h20, 4, 4'hF, 0);
    check("wr_burst_last_word", last_rd, 32'hC0DE0004);

    // read burst of 3 stalled 3 cycles on beat 2
    pat_len = 9;
    bry_pat[0] = 1; bry_pat[1] = 1; bry_pat[2] = 1; bry_pat[3] = 0; bry_pat[4] = 0;
    bry_pat[5] = 0; bry_pat[6] = 1; bry_pat[7] = 1; bry_pat[8] = 1;
    run_burst(1'b0, 32'h40, 3, 4'hF, -1);
    av = '0; lv = '0;
    for (int c = 1; c <= 10; c++) begin
      av[c] = alog[c];
      lv[c] = llog[c];
    end
    check("rd_stall_ack_cycles", 32'(av), 32'h508);
    check("rd_stall_lack_cycles", 32'(lv), 32'h400);
    for (int c = 4; c <= 8; c++)
      check($sformatf("rd_stall_hold[%0d]", c), dlog[c], ref_mem[word_idx(32'h40) + 1]);

    // reset during beat 2 of a 4-beat read
    wbd_stb_i = 1'b1; wbd_we_i = 1'b0; wbd_adr_i = 32'h20; wbd_bl_i = BL_W'(4);
    wbd_sel_i = 4'hF; wbd_bry_i = 1'b1;
    tick(); tick(); tick();
    check("rst_seq_beat1_ack", 32'(wbd_ack_o), 32'h1);
    check("rst_seq_beat1_dat", wbd_dat_o, ref_mem[8]);
    tick();
    wb_rst = 1'b1;
    tick();
    check("midrst_ack", 32'(wbd_ack_o), 32'h0);
    check("midrst_lack", 32'(wbd_lack_o), 32'h0);
    check("midrst_dat", wbd_dat_o, 32'h0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    wbd_stb_i = 1'b0;
    tick();
    wb_rst = 1'b0;
    late_acks = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      late_acks += int'(wbd_ack_o);
    end
    check("no_ack_after_rst", 32'(late_acks), 32'h0);
    run_burst(1'b0, 32'h20, 4, 4'hF, 30);

`ifdef YCR_WB_TGT_ERR_EN
    // out-of-window request: error answer, memory untouched
    old_w = ref_mem[0];
    wbd_stb_i = 1'b1; wbd_we_i = 1'b1; wbd_adr_i = 32'h400; wbd_dat_i = 32'h5A5A0001;
    wbd_bl_i = BL_W'(1); wbd_sel_i = 4'hF; wbd_bry_i = 1'b1;
    tick();
    check("range_err", {29'h0, wbd_ack_o, wbd_lack_o, wbd_err_o}, 32'h7);
    wbd_stb_i = 1'b0;
    tick();
    check("range_err_idle", 32'(dbg_state), 32'(ST_IDLE));
    run_burst(1'b0, 32'h0, 1, 4'hF, 0);
    check("range_err_mem", last_rd, old_w);

    // wrapping write burst: third beat terminates with error
    old_w = ref_mem[0];
    wbd_stb_i = 1'b1; wbd_we_i = 1'b1; wbd_adr_i = 32'h3F8; wbd_bl_i = BL_W'(3);
    wbd_sel_i = 4'hF; wbd_bry_i = 1'b1;
    tick();
    wbd_dat_i = 32'hBEEF00FE;
    tick();
    wbd_dat_i = 32'hBEEF00FF;
    tick();
    wbd_dat_i = 32'hBEEF0000;
    tick();
    check("wrap_err", {29'h0, wbd_ack_o, wbd_lack_o, wbd_err_o}, 32'h7);
    ref_mem[WORDS-2] = 32'hBEEF00FE;
    ref_mem[WORDS-1] = 32'hBEEF00FF;
    wbd_stb_i = 1'b0;
    tick();
    run_burst(1'b0, 32'h3F8, 2, 4'hF, 0);
    run_burst(1'b0, 32'h0, 1, 4'hF, 0);
    check("wrap_err_mem", last_rd, old_w);
`else
    // upper address bits ignored: 0x400 aliases word 0
    wbuf[0] = 32'h5A5A0001;
    run_burst(1'b1, 32'h400, 1, 4'hF, 0);
    run_burst(1'b0, 32'h0, 1, 4'hF, 0);
    check("alias_word0", last_rd, 32'h5A5A0001);

    // burst wrapping from the top word to word 0
    wbuf[0] = 32'h77770000; wbuf[1] = 32'h77770001; wbuf[2] = 32'h77770002;
    run_burst(1'b1, 32'h3F8, 3, 4'hF, 20);
    run_burst(1'b0, 32'h3F8, 3, 4'hF, 20);
    check("wrap_word0", last_rd, 32'h77770002);
`endif

    // randomized bursts against the memory model
    for (int i = 0; i < 40; i++) begin
      we_r  = bit'($urandom_range(1));
      idx_r = int'($urandom_range(WORDS - 1));
      bl_r  = int'($urandom_range(8));
      n_r   = (bl_r == 0) ? 1 : bl_r;
`ifdef YCR_WB_TGT_ERR_EN
      if (idx_r + n_r > WORDS) idx_r = WORDS - n_r;
      adr_r = {22'h0, 8'(idx_r), 2'($urandom_range(3))};
`else
      adr_r = {22'($urandom), 8'(idx_r), 2'($urandom_range(3))};
`endif
      for (int k = 0; k < n_r; k++) wbuf[k] = $urandom;
      run_burst(we_r, adr_r, bl_r, 4'($urandom_range(15)), int'($urandom_range(60)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
